// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Steps through animation frames stored back-to-back in flash. A free-running
// prescaler produces one tick every CLK_HZ/FPS cycles. Each tick (or a step
// while paused, or a restart) computes the next frame index according to the
// play mode. It then issues a one-cycle load request carrying that frame's
// flash address and waits for the loader to report completion.
//
// Optional feature (macro FRAME_SEQ_SKIP_EN):
//   defined   : a tick that arrives while a load is outstanding is dropped
//               and counted in o_skip_count (saturating at 255).
//   undefined : such a tick is remembered in a single-deep pending flag and
//               serviced once the sequencer is idle again.
//
// Ports:
//   clk_48mhz, reset    clock, synchronous active-high reset
//   i_last_frame        index of the final frame
//   i_mode              00 loop, 01 ping-pong, 10 one-shot, 11 loop
//   i_pause, i_step     pause tick advance; single step while paused
//   i_restart           jump to frame 0, direction up, clear o_done
//   o_load_addr         flash address of the current frame
//   o_load_stb          one-cycle load request
//   i_load_done         one-cycle completion strobe from the loader
//   o_frame_index       current frame index
//   o_led               toggles on every tick
//   o_done              one-shot playback finished
//   o_busy              load outstanding
//   o_skip_count        dropped ticks (FRAME_SEQ_SKIP_EN only)
//   o_dbg_state         FSM state (0 idle, 1 issue, 2 wait_load)
//
// Load handshake: o_load_stb is high for exactly one cycle (ISSUE).
// o_load_addr is valid from that cycle until the loader answers. The loader
// answers with a single-cycle i_load_done. A strobe is accepted only in
// WAIT_LOAD; at any other time it is ignored.
// -----------------------------------------------------------------------------
module frame_sequencer #(
  parameter int unsigned CLK_HZ      = 48_000_000,
  parameter int unsigned FPS         = 10,
  parameter int unsigned IDX_W       = 8,
  parameter int unsigned FRAME_SHIFT = 13,
  parameter logic [23:0] FLASH_BASE  = 24'h80_0000
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_last_frame,
  input  logic [1:0]       i_mode,
  input  logic             i_pause,
  input  logic             i_step,
  input  logic             i_restart,
  output logic [23:0]      o_load_addr,
  output logic             o_load_stb,
  input  logic             i_load_done,
  output logic [IDX_W-1:0] o_frame_index,
  output logic             o_led,
  output logic             o_done,
  output logic             o_busy,
`ifdef FRAME_SEQ_SKIP_EN
  output logic [7:0]       o_skip_count,
`endif
  output logic [1:0]       o_dbg_state
);

  localparam int unsigned PRESCALER   = CLK_HZ / FPS - 1;
  localparam int unsigned CNT_W       = (PRESCALER > 0) ? $clog2(PRESCALER + 1) : 1;
  localparam logic [CNT_W-1:0] PRESCALER_V = CNT_W'(PRESCALER);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_LOAD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dir_up_q, dir_up_d;
  logic             led_q, led_d;
  logic             done_q, done_d;
  logic             final_q, final_d;        // load in flight is the one-shot last frame
  logic             restart_pend_q, restart_pend_d;
  logic             boot_q, boot_d;          // high for the first cycle out of reset

  logic             tick;
  logic             tick_src;
  logic             restart_req;
  logic             adv_req;
  logic             oneshot;
  logic [IDX_W-1:0] next_idx;
  logic             next_up;

`ifdef FRAME_SEQ_SKIP_EN
  logic [7:0] skip_q, skip_d;
  assign tick_src = tick && !i_pause;
`else
  logic tick_pend_q, tick_pend_d;
  assign tick_src = (tick && !i_pause) || tick_pend_q;
`endif

  assign tick        = (cnt_q == '0);
  assign oneshot     = (i_mode == 2'b10);
  // The implicit restart out of reset reuses the ordinary restart path.
  assign restart_req = i_restart || restart_pend_q || boot_q;
  // Once one-shot playback has finished, only a restart can move the index.
  assign adv_req     = !done_q && (tick_src || (i_step && i_pause));

  // Next index for a tick/step advance. Mode and last frame are sampled here only.
  always_comb begin
    next_idx = idx_q;
    next_up  = dir_up_q;
    case (i_mode)
      2'b01: begin
        if (i_last_frame == '0) begin
          next_idx = '0;
          next_up  = 1'b1;
        end else if (idx_q > i_last_frame) begin
          next_idx = i_last_frame;
          next_up  = 1'b0;
        end else if (dir_up_q) begin
          if (idx_q == i_last_frame) begin
            next_idx = idx_q - 1'b1;
            next_up  = 1'b0;
          end else begin
            next_idx = idx_q + 1'b1;
          end
        end else begin
          if (idx_q == '0) begin
            next_idx = idx_q + 1'b1;
            next_up  = 1'b1;
          end else begin
            next_idx = idx_q - 1'b1;
          end
        end
      end
      2'b10: next_idx = (idx_q >= i_last_frame) ? i_last_frame : idx_q + 1'b1;
      default: next_idx = (idx_q >= i_last_frame) ? '0 : idx_q + 1'b1;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = tick ? PRESCALER_V : cnt_q - 1'b1;
    led_d          = led_q ^ tick;
    idx_d          = idx_q;
    dir_up_d       = dir_up_q;
    done_d         = done_q;
    final_d        = final_q;
    restart_pend_d = restart_pend_q;
    boot_d         = 1'b0;
`ifdef FRAME_SEQ_SKIP_EN
    skip_d         = skip_q;
`else
    tick_pend_d    = tick_pend_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Anything pending is either serviced now or superseded by a restart.
        restart_pend_d = 1'b0;
`ifndef FRAME_SEQ_SKIP_EN
        tick_pend_d    = 1'b0;
`endif
        if (restart_req) begin
          idx_d    = '0;
          dir_up_d = 1'b1;
          done_d   = 1'b0;
          final_d  = oneshot && (i_last_frame == '0);
          state_d  = ST_ISSUE;
        end else if (adv_req) begin
          idx_d    = next_idx;
          dir_up_d = next_up;
          final_d  = oneshot && (next_idx == i_last_frame);
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_LOAD;
      ST_WAIT_LOAD: begin
        if (i_load_done) begin
          state_d = ST_IDLE;
          if (final_q) done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) begin
      if (i_restart) restart_pend_d = 1'b1;
      if (tick && !i_pause) begin
`ifdef FRAME_SEQ_SKIP_EN
        if (skip_q != 8'hFF) skip_d = skip_q + 8'd1;
`else
        tick_pend_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= PRESCALER_V;
      idx_q          <= '0;
      dir_up_q       <= 1'b1;
      led_q          <= 1'b0;
      done_q         <= 1'b0;
      final_q        <= 1'b0;
      restart_pend_q <= 1'b0;
      boot_q         <= 1'b1;
`ifdef FRAME_SEQ_SKIP_EN
      skip_q         <= 8'd0;
`else
      tick_pend_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      dir_up_q       <= dir_up_d;
      led_q          <= led_d;
      done_q         <= done_d;
      final_q        <= final_d;
      restart_pend_q <= restart_pend_d;
      boot_q         <= boot_d;
`ifdef FRAME_SEQ_SKIP_EN
      skip_q         <= skip_d;
`else
      tick_pend_q    <= tick_pend_d;
`endif
    end
  end

  // Index only changes on entry to ISSUE, so the address holds through the load.
  assign o_load_addr   = FLASH_BASE + 24'({24'd0, idx_q} << FRAME_SHIFT);
  assign o_load_stb    = (state_q == ST_ISSUE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_frame_index = idx_q;
  assign o_led         = led_q;
  assign o_done        = done_q;
  assign o_dbg_state   = state_q;
`ifdef FRAME_SEQ_SKIP_EN
  assign o_skip_count  = skip_q;
`endif

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CLK_HZ, 48_000_000, clock frequency in Hz.
REQ-002 FPS, 10, frame advance rate; PRESCALER = CLK_HZ/FPS - 1.
REQ-003 IDX_W, 8, frame index width.
REQ-004 FRAME_SHIFT, 13, log2 bytes per frame in flash.
REQ-005 FLASH_BASE, 24'h80_0000, flash address of frame 0.
REQ-006 Ports SHALL be (name, direction, width, meaning): clk_48mhz, in, 1, clock; reset, in, 1, synchronous active-high reset.
REQ-007 i_last_frame, in, IDX_W, index of final frame.
REQ-008 i_mode, in, 2: 00 loop, 01 ping-pong, 10 one-shot, 11 treated as loop.
REQ-009 i_pause, in, 1, suppress tick-driven advance; i_step, in, 1, single-cycle advance request, honoured only while paused.
REQ-010 i_restart, in, 1, strobe: index to 0, direction up, clear o_done, issue load.
REQ-011 o_load_addr, out, 24, flash read address; o_load_stb, out, 1, one-cycle load request.
REQ-012 i_load_done, in, 1, one-cycle completion strobe from loader.
REQ-013 o_frame_index, out, IDX_W; o_led, out, 1, toggles per tick; o_done, out, 1, one-shot finished; o_busy, out, 1, load outstanding.

Function
REQ-014 Prescaler SHALL count down from PRESCALER to 0; a tick SHALL be one cycle when count is 0, count then reloading PRESCALER; the prescaler SHALL run regardless of pause.
REQ-015 o_led SHALL toggle on every tick.
REQ-016 States SHALL be IDLE, ISSUE, WAIT_LOAD; IDLE->ISSUE on advance request, ISSUE->WAIT_LOAD unconditionally after one cycle, WAIT_LOAD->IDLE on i_load_done.
REQ-017 Advance request SHALL be: tick with i_pause=0, or i_step with i_pause=1, or i_restart.
REQ-018 On IDLE->ISSUE the next index SHALL be computed and registered; o_load_stb SHALL be high exactly during ISSUE.
REQ-019 o_load_addr SHALL equal (FLASH_BASE + (index << FRAME_SHIFT)) truncated to 24 bits, stable from ISSUE until i_load_done.
REQ-020 Loop: index == i_last_frame or index > i_last_frame -> 0, else +1.
REQ-021 Ping-pong: at i_last_frame direction flips to down, at 0 flips to up; i_last_frame == 0 holds index 0; index > i_last_frame clamps to i_last_frame with direction down.
REQ-022 One-shot: index stops at i_last_frame, o_done set when that frame's load completes; further ticks/steps ignored until i_restart or reset.
REQ-023 i_mode and i_last_frame SHALL be sampled only at advance computation.
REQ-024 o_busy SHALL be high in ISSUE and WAIT_LOAD.
REQ-025 i_restart SHALL take priority over tick and step in the same cycle; i_restart during WAIT_LOAD SHALL be held pending and serviced on return to IDLE.
REQ-026 i_load_done outside WAIT_LOAD SHALL be ignored.

Reset
REQ-027 Reset SHALL set index 0, direction up, prescaler PRESCALER, state IDLE, o_load_stb 0, o_led 0, o_done 0, pending flags 0.
REQ-028 In the first cycle after reset deasserts, an implicit restart SHALL issue a load of frame 0 (o_load_addr = FLASH_BASE).
REQ-029 Reset asserted mid-load SHALL abandon the load without waiting for i_load_done.

Configuration
REQ-030 Macro FRAME_SEQ_SKIP_EN: defined -> a tick arriving outside IDLE is dropped and o_skip_count (out, 8) increments, saturating at 255, reset to 0.
REQ-031 Macro absent -> a tick outside IDLE sets a single-deep pending flag (multiple ticks collapse to one), serviced in the cycle after return to IDLE; o_skip_count absent.

Verification (CLK_HZ=100, FPS=10, PRESCALER=9, FRAME_SHIFT=13)
REQ-032 Release reset, loader done 3 cycles after stb -> stb cycle 1 with addr 0x800000, then stb every 10 cycles with addr 0x802000, 0x804000.
REQ-033 Loop, i_last_frame=2, 7 ticks -> index sequence 0,1,2,0,1,2,0,1.
REQ-034 Ping-pong, i_last_frame=3 -> 0,1,2,3,2,1,0,1; i_last_frame=0 -> constant 0.
REQ-035 One-shot, i_last_frame=2 -> o_done high after frame 2 done, no further stb; i_restart -> stb addr 0x800000, o_done low.
REQ-036 Loader done delayed 25 cycles -> macro defined: o_skip_count=2, one stb per done; macro absent: exactly one extra stb the cycle after done.
REQ-037 i_pause=1 -> no stb across 30 cycles; i_step pulse -> one stb, index +1; reset pulse in WAIT_LOAD -> o_busy 0 next cycle, new frame-0 stb.
